// File: rtl/commit_mon_pkg.sv
// Shared types for the commit monitor: FSM states, default trace entry layout
// and the saturating counter helper.
package commit_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } mon_state_t;

  localparam int unsigned DEF_XLEN = 64;
  localparam int unsigned DEF_PC_W = 64;
  localparam int unsigned DEF_RA_W = 5;

  typedef struct packed {
    logic [DEF_RA_W-1:0] rd;
    logic [DEF_XLEN-1:0] data;
    logic [DEF_PC_W-1:0] pc;
  } trace_entry_t;

  // Counters up to 64 bits share this; callers pass their own all-ones ceiling.
  function automatic logic [63:0] sat_inc(input logic [63:0] value, input logic [63:0] max);
    return (value >= max) ? max : value + 64'd1;
  endfunction

endpackage

// File: rtl/commit_monitor_if.sv
// Writeback capture and trace drain port of the commit monitor.
// master = core/consumer side, slave = monitor side.
interface commit_monitor_if #(
  parameter int XLEN = 64,
  parameter int PC_W = 64,
  parameter int RA_W = 5
);
  logic            wb_valid;
  logic [RA_W-1:0] wb_rd;
  logic [XLEN-1:0] wb_data;
  logic [PC_W-1:0] wb_pc;
  logic            trace_valid;
  logic            trace_ready;
  logic [RA_W-1:0] trace_rd;
  logic [XLEN-1:0] trace_data;
  logic [PC_W-1:0] trace_pc;

  modport master (
    output wb_valid, wb_rd, wb_data, wb_pc, trace_ready,
    input  trace_valid, trace_rd, trace_data, trace_pc
  );

  modport slave (
    input  wb_valid, wb_rd, wb_data, wb_pc, trace_ready,
    output trace_valid, trace_rd, trace_data, trace_pc
  );
endinterface

// File: rtl/commit_trace_fifo.sv
// DEPTH-entry synchronous trace FIFO; a push while full is accepted only when
// a pop frees the slot in the same cycle.
module commit_trace_fifo
  import commit_mon_pkg::*;
#(
  parameter int  DEPTH   = 16,
  parameter type entry_t = trace_entry_t
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  output entry_t head,
  output logic   head_valid,
  output logic   full,
  output logic   empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Zero fields while empty so nothing stale is visible after reset.
  assign head_valid = !empty;
  assign head       = empty ? '0 : mem[rd_ptr];
endmodule

// File: rtl/commit_monitor.sv
// Retirement monitor: trace FIFO, watched register, counters and halt detection.
// Define COMMIT_MON_STALL_CNT_EN to build the stall counter (tied to 0 otherwise).
//
// state  | meaning
// IDLE   | one cycle after reset, nothing observed
// RUN    | capturing retires, watching fetch PC for a freeze
// DRAIN  | program ended, waiting for the trace FIFO to empty
// HALTED | program ended and trace drained, held until reset
module commit_monitor
  import commit_mon_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int PC_W      = 64,
  parameter int RA_W      = 5,
  parameter int DEPTH     = 16,
  parameter int WATCH_REG = 4,
  parameter int HALT_IDLE = 8,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  commit_monitor_if.slave  bus,
  input  logic [PC_W-1:0]  if_pc,
  input  logic             stall_in,
  output logic [XLEN-1:0]  watch_value,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] stall_count,
  output logic             overflow,
  output logic             halted,
  output logic [1:0]       state
);
  typedef struct packed {
    logic [RA_W-1:0] rd;
    logic [XLEN-1:0] data;
    logic [PC_W-1:0] pc;
  } entry_t;

  localparam int IW = $clog2(HALT_IDLE + 1);
  localparam logic [IW-1:0] IDLE_LOAD = IW'(HALT_IDLE);
  localparam logic [63:0]   CNT_MAX   = (64'd1 << CNT_W) - 64'd1;

  mon_state_t      st, st_next;
  logic [IW-1:0]   idle_left, idle_next;
  logic [PC_W-1:0] prev_pc;
  logic            retire, push, pop, fifo_full, fifo_empty;
  entry_t          wb_entry, head;

  assign retire   = (st == ST_RUN) && bus.wb_valid;
  assign push     = retire && (bus.wb_rd != '0);
  assign pop      = (st != ST_IDLE) && !fifo_empty && bus.trace_ready;
  assign wb_entry = '{rd: bus.wb_rd, data: bus.wb_data, pc: bus.wb_pc};

  commit_trace_fifo #(.DEPTH(DEPTH), .entry_t(entry_t)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_data  (wb_entry),
    .pop        (pop),
    .head       (head),
    .head_valid (bus.trace_valid),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  assign bus.trace_rd   = head.rd;
  assign bus.trace_data = head.data;
  assign bus.trace_pc   = head.pc;

  // Idle timer counts down from HALT_IDLE; reaching zero marks program end.
  always_comb begin
    st_next   = st;
    idle_next = IDLE_LOAD;
    unique case (st)
      ST_IDLE: st_next = ST_RUN;
      ST_RUN: begin
        if (if_pc != prev_pc) idle_next = IDLE_LOAD;
        else if (stall_in)    idle_next = idle_left;
        else                  idle_next = idle_left - 1'b1;
        if (idle_next == '0) st_next = ST_DRAIN;
      end
      ST_DRAIN:  if (fifo_empty) st_next = ST_HALTED;
      ST_HALTED: st_next = ST_HALTED;
      default:   st_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    prev_pc <= if_pc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st          <= ST_IDLE;
      idle_left   <= IDLE_LOAD;
      watch_value <= '0;
      cycle_count <= '0;
      instr_count <= '0;
      overflow    <= 1'b0;
    end else begin
      st        <= st_next;
      idle_left <= idle_next;
      if (st == ST_RUN || st == ST_DRAIN)
        cycle_count <= CNT_W'(sat_inc(64'(cycle_count), CNT_MAX));
      if (retire)
        instr_count <= CNT_W'(sat_inc(64'(instr_count), CNT_MAX));
      if (push && bus.wb_rd == RA_W'(WATCH_REG))
        watch_value <= bus.wb_data;
      if (push && fifo_full && !pop)
        overflow <= 1'b1;
    end
  end

`ifdef COMMIT_MON_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)                          stall_count <= '0;
    else if (st == ST_RUN && stall_in)  stall_count <= CNT_W'(sat_inc(64'(stall_count), CNT_MAX));
  end
`else
  assign stall_count = '0;
`endif

  assign state  = st;
  assign halted = (st == ST_HALTED);
endmodule

// File: tb/tb_commit_monitor.sv
// Self-checking bench for commit_monitor: directed tables and sequences plus a
// randomized run checked every cycle against a queue-based reference model.
module tb_commit_monitor;
  localparam int XLEN = 32, PC_W = 32, RA_W = 5, DEPTH = 4;
  localparam int WATCH = 4, HALT = 8, CNT_W = 8, CMAX = 255;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [PC_W-1:0]  if_pc = 32'h1000;
  logic             stall_in = 1'b0;
  logic [XLEN-1:0]  watch_value;
  logic [CNT_W-1:0] cycle_count, instr_count, stall_count;
  logic             overflow, halted;
  logic [1:0]       state;

  commit_monitor_if #(.XLEN(XLEN), .PC_W(PC_W), .RA_W(RA_W)) bus ();

  commit_monitor #(
    .XLEN(XLEN), .PC_W(PC_W), .RA_W(RA_W), .DEPTH(DEPTH),
    .WATCH_REG(WATCH), .HALT_IDLE(HALT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .if_pc(if_pc), .stall_in(stall_in),
    .watch_value(watch_value), .cycle_count(cycle_count), .instr_count(instr_count),
    .stall_count(stall_count), .overflow(overflow), .halted(halted), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [RA_W-1:0] rd;
    logic [XLEN-1:0] data;
    logic [PC_W-1:0] pc;
  } ent_t;

  typedef struct {
    logic [RA_W-1:0] rd;
    logic [XLEN-1:0] data;
    bit              traced;
    logic [XLEN-1:0] exp_watch;
  } vec_t;

  ent_t            mq[$];
  int              m_st, m_idle, m_cyc, m_ins, m_stl;
  logic [PC_W-1:0] m_prev;
  logic [XLEN-1:0] m_watch;
  bit              m_ovf;
  bit              freeze;
  int              total = 0, bad = 0;
  vec_t            tbl[9];
  int              frz_len;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic model_step();
    bit   was_empty, pop, push;
    ent_t e;
    if (reset) begin
      mq.delete();
      m_st = 0; m_idle = 0; m_watch = '0;
      m_cyc = 0; m_ins = 0; m_stl = 0; m_ovf = 0;
    end else begin
      was_empty = (mq.size() == 0);
      pop  = (m_st != 0) && !was_empty && bus.trace_ready;
      push = (m_st == 1) && bus.wb_valid && (bus.wb_rd != 0);
      if (m_st == 1 || m_st == 2) m_cyc = sat(m_cyc);
      if (m_st == 1 && bus.wb_valid) m_ins = sat(m_ins);
      if (m_st == 1 && stall_in) m_stl = sat(m_stl);
      if (push && bus.wb_rd == WATCH) m_watch = bus.wb_data;
      if (pop) void'(mq.pop_front());
      if (push) begin
        e.rd = bus.wb_rd; e.data = bus.wb_data; e.pc = bus.wb_pc;
        if (mq.size() < DEPTH) mq.push_back(e);
        else m_ovf = 1;
      end
      case (m_st)
        0: m_st = 1;
        1: begin
          if (if_pc != m_prev) m_idle = 0;
          else if (!stall_in)  m_idle++;
          if (m_idle >= HALT) m_st = 2;
        end
        2: if (was_empty) m_st = 3;
        default: ;
      endcase
      if (m_st != 1) m_idle = 0;
    end
    m_prev = if_pc;
  endtask

  task automatic compare_all();
    ent_t h;
    int   exp_stl;
    h.rd = '0; h.data = '0; h.pc = '0;
    if (mq.size() > 0) h = mq[0];
`ifdef COMMIT_MON_STALL_CNT_EN
    exp_stl = m_stl;
`else
    exp_stl = 0;
`endif
    chk("state", 64'(state), 64'(m_st));
    chk("trace_valid", 64'(bus.trace_valid), 64'(mq.size() > 0));
    chk("trace_rd", 64'(bus.trace_rd), 64'(h.rd));
    chk("trace_data", 64'(bus.trace_data), 64'(h.data));
    chk("trace_pc", 64'(bus.trace_pc), 64'(h.pc));
    chk("watch_value", 64'(watch_value), 64'(m_watch));
    chk("cycle_count", 64'(cycle_count), 64'(m_cyc));
    chk("instr_count", 64'(instr_count), 64'(m_ins));
    chk("stall_count", 64'(stall_count), 64'(exp_stl));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("halted", 64'(halted), 64'(m_st == 3));
  endtask

  task automatic cycle();
    if (!freeze) if_pc = if_pc + 32'd4;
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    tbl[0] = '{5'd4, 32'd1,     1'b1, 32'd1};
    tbl[1] = '{5'd4, 32'd1,     1'b1, 32'd1};
    tbl[2] = '{5'd4, 32'd2,     1'b1, 32'd2};
    tbl[3] = '{5'd4, 32'd3,     1'b1, 32'd3};
    tbl[4] = '{5'd4, 32'd5,     1'b1, 32'd5};
    tbl[5] = '{5'd4, 32'd8,     1'b1, 32'd8};
    tbl[6] = '{5'd0, 32'h55,    1'b0, 32'd8};
    tbl[7] = '{5'd7, 32'h99,    1'b1, 32'd8};
    tbl[8] = '{5'd4, 32'h21,    1'b1, 32'h21};

    bus.wb_valid = 0; bus.wb_rd = '0; bus.wb_data = '0; bus.wb_pc = '0;
    bus.trace_ready = 0; freeze = 0; frz_len = 0;
    m_prev = '0;

    // reset state
    reset = 1; cycle(); cycle();
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_valid", 64'(bus.trace_valid), 64'd0);
    chk("rst_cycles", 64'(cycle_count), 64'd0);
    reset = 0; cycle();
    chk("run_after_reset", 64'(state), 64'd1);
    cycle(); cycle();

    // retire table with consumer always ready
    bus.trace_ready = 1;
    for (int i = 0; i < 9; i++) begin
      bus.wb_valid = 1; bus.wb_rd = tbl[i].rd; bus.wb_data = tbl[i].data;
      bus.wb_pc = 32'h2000 + 32'(i * 4);
      cycle();
      chk("tbl_valid", 64'(bus.trace_valid), 64'(tbl[i].traced));
      if (tbl[i].traced) chk("tbl_data", 64'(bus.trace_data), 64'(tbl[i].data));
      chk("tbl_watch", 64'(watch_value), 64'(tbl[i].exp_watch));
    end
    bus.wb_valid = 0; cycle();
    chk("tbl_instr", 64'(instr_count), 64'd9);
    chk("tbl_drained", 64'(bus.trace_valid), 64'd0);

    // fill, push+pop while full, then overflow
    reset = 1; cycle(); reset = 0; cycle();
    bus.trace_ready = 0;
    for (int i = 0; i < 4; i++) begin
      bus.wb_valid = 1; bus.wb_rd = 5'd5; bus.wb_data = 32'h10 + 32'(i); bus.wb_pc = 32'h3000 + 32'(i);
      cycle();
    end
    chk("full_no_ovf", 64'(overflow), 64'd0);
    bus.trace_ready = 1; bus.wb_rd = 5'd6; bus.wb_data = 32'h77;
    cycle();
    chk("pushpop_full_ovf", 64'(overflow), 64'd0);
    chk("pushpop_full_head", 64'(bus.trace_data), 64'h11);
    bus.trace_ready = 0;
    bus.wb_data = 32'h80; cycle();
    bus.wb_data = 32'h81; cycle();
    chk("ovf_set", 64'(overflow), 64'd1);
    bus.wb_valid = 0; cycle(); cycle();
    chk("head_stable", 64'(bus.trace_data), 64'h11);

    // reset mid-run with entries queued
    reset = 1; cycle();
    chk("midrst_valid", 64'(bus.trace_valid), 64'd0);
    chk("midrst_instr", 64'(instr_count), 64'd0);
    chk("midrst_state", 64'(state), 64'd0);
    chk("midrst_ovf", 64'(overflow), 64'd0);
    reset = 0; cycle();
    chk("midrst_run", 64'(state), 64'd1);

    // freeze with 2 entries queued -> DRAIN -> HALTED
    bus.wb_valid = 1; bus.wb_rd = 5'd9;
    bus.wb_data = 32'hA0; cycle();
    bus.wb_data = 32'hA1; cycle();
    bus.wb_valid = 0;
    freeze = 1; if_pc = 32'h40; cycle();
    for (int i = 0; i < 7; i++) cycle();
    chk("freeze_not_yet", 64'(state), 64'd1);
    cycle();
    chk("freeze_drain", 64'(state), 64'd2);
    bus.trace_ready = 1;
    cycle(); chk("drain_pop1", 64'(state), 64'd2);
    cycle(); chk("drain_pop2", 64'(state), 64'd2);
    chk("drain_empty", 64'(bus.trace_valid), 64'd0);
    cycle(); chk("halted_state", 64'(state), 64'd3);
    chk("halted_flag", 64'(halted), 64'd1);
    bus.wb_valid = 1; bus.wb_rd = 5'd4; bus.wb_data = 32'hDEAD; cycle();
    chk("halted_ignore_watch", 64'(watch_value), 64'd0);
    chk("halted_hold", 64'(state), 64'd3);
    bus.wb_valid = 0; bus.trace_ready = 0;

    // stalls during the freeze delay DRAIN and feed the stall counter
    reset = 1; cycle(); reset = 0; freeze = 0; cycle();
    freeze = 1; if_pc = 32'h40; cycle();
    for (int i = 0; i < 4; i++) cycle();
    stall_in = 1;
    for (int i = 0; i < 3; i++) cycle();
    stall_in = 0;
    for (int i = 0; i < 3; i++) cycle();
    chk("stall_extends", 64'(state), 64'd1);
`ifdef COMMIT_MON_STALL_CNT_EN
    chk("stall_count3", 64'(stall_count), 64'd3);
`else
    chk("stall_count_off", 64'(stall_count), 64'd0);
`endif
    cycle();
    chk("stall_drain", 64'(state), 64'd2);
    cycle();
    chk("stall_halted", 64'(halted), 64'd1);

    // counter saturation
    reset = 1; cycle(); reset = 0; freeze = 0;
    stall_in = 1; bus.wb_valid = 1; bus.wb_rd = '0;
    for (int i = 0; i < 300; i++) cycle();
    chk("sat_cycle", 64'(cycle_count), 64'd255);
    chk("sat_instr", 64'(instr_count), 64'd255);
`ifdef COMMIT_MON_STALL_CNT_EN
    chk("sat_stall", 64'(stall_count), 64'd255);
`else
    chk("sat_stall_off", 64'(stall_count), 64'd0);
`endif
    stall_in = 0; bus.wb_valid = 0;

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      if (frz_len > 0) begin
        freeze = 1; frz_len--;
      end else begin
        freeze = 0;
        if ($urandom_range(0, 19) == 0) frz_len = $urandom_range(2, 14);
      end
      reset           = ($urandom_range(0, 99) == 0);
      bus.wb_valid    = $urandom_range(0, 1) == 1;
      bus.wb_rd       = RA_W'($urandom_range(0, 7));
      bus.wb_data     = $urandom;
      bus.wb_pc       = $urandom;
      bus.trace_ready = $urandom_range(0, 4) < 2;
      stall_in        = $urandom_range(0, 3) == 0;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
